// File: rtl/kw_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// kw_fetch_sequencer
//
// Walks through the kernel-weight ROMs one word at a time and hands each word
// to the conv engine. For every word it selects the filter (F) on the 8:1
// KW-select mux and the shared ROM address, pulses the ROM enable for one
// cycle, waits out the ROM read latency, captures the mux output into a
// register and then offers it to the engine with a valid/ready handshake.
// Filters are visited in order 0..nfilt_m1 and, inside each filter, words in
// order 0..nword_m1.
//
// Parameters
//   KW_W     width of one kernel-weight word
//   ADDR_W   ROM address width
//   ROM_LAT  cycles from rom_en to valid data at the mux output (>= 1)
//
// Ports
//   clk           clock, everything on the rising edge
//   rst_n         synchronous active-low reset
//   start         pulse from the layer controller, only honoured when idle
//   cfg_nfilt_m1  number of filters minus one, latched at start
//   cfg_nword_m1  words per filter minus one, latched at start
//   rom_kw_in     KW-select mux output
//   F             filter select to the KW-select mux / ROM bank
//   rom_addr      address shared by all ROMs
//   rom_en        ROM read enable, high only in the fetch cycle
//   kw_data       registered weight word to the engine
//   kw_valid      kw_data is valid
//   kw_ready      engine accepts kw_data
//   kw_last       with kw_valid: last word of the current filter
//   busy          high whenever a run is in progress
//   done          one-cycle pulse when the run completes
// ---------------------------------------------------------------------------
module kw_fetch_sequencer #(
  parameter int KW_W    = 384,
  parameter int ADDR_W  = 6,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        cfg_nfilt_m1,
  input  logic [ADDR_W-1:0] cfg_nword_m1,
  input  logic [KW_W-1:0]   rom_kw_in,
  output logic [2:0]        F,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  output logic [KW_W-1:0]   kw_data,
  output logic              kw_valid,
  input  logic              kw_ready,
  output logic              kw_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(ROM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ROM_LAT);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q,   state_d;
  logic [2:0]        filtSel_q, filtSel_d;
  logic [ADDR_W-1:0] romAddr_q, romAddr_d;
  logic [2:0]        nfiltM1_q, nfiltM1_d;
  logic [ADDR_W-1:0] nwordM1_q, nwordM1_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [KW_W-1:0]   kwData_q,  kwData_d;
  logic              lastWord;

  // The word currently held is the final one of its filter once the address
  // has reached the latched words-per-filter limit.
  assign lastWord = (romAddr_q == nwordM1_q);

  // Next-state logic. Everything defaults to holding its value so that a
  // stalled HOLD keeps data, filter and address perfectly still. The filter
  // and address only ever move on an accepted beat or when the run ends, so
  // the mux path is stable from the fetch cycle up to the capture edge.
  // Configuration is copied only when a start is taken in IDLE, which makes
  // mid-run cfg changes and stray start pulses harmless.
  always_comb begin
    state_d   = state_q;
    filtSel_d = filtSel_q;
    romAddr_d = romAddr_q;
    nfiltM1_d = nfiltM1_q;
    nwordM1_d = nwordM1_q;
    waitCnt_d = waitCnt_q;
    kwData_d  = kwData_q;

    case (state_q)
      IDLE: begin
        filtSel_d = 3'd0;
        romAddr_d = '0;
        if (start) begin
          nfiltM1_d = cfg_nfilt_m1;
          nwordM1_d = cfg_nword_m1;
          state_d   = FETCH;
        end
      end

      FETCH: begin
        waitCnt_d = LAT_LOAD;
        state_d   = WAIT;
      end

      WAIT: begin
        waitCnt_d = waitCnt_q - 1'b1;
        if (waitCnt_q == LAT_LAST) begin
          kwData_d = rom_kw_in;
          state_d  = HOLD;
        end
      end

      HOLD: begin
        if (kw_ready) begin
          if (!lastWord) begin
            romAddr_d = romAddr_q + 1'b1;
            state_d   = FETCH;
          end else if (filtSel_q < nfiltM1_q) begin
            filtSel_d = filtSel_q + 3'd1;
            romAddr_d = '0;
            state_d   = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        filtSel_d = 3'd0;
        romAddr_d = '0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset is synchronous and wins over any
  // transition, so a reset in the middle of a run drops straight to IDLE
  // with every register cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      filtSel_q <= 3'd0;
      romAddr_q <= '0;
      nfiltM1_q <= 3'd0;
      nwordM1_q <= '0;
      waitCnt_q <= '0;
      kwData_q  <= '0;
    end else begin
      state_q   <= state_d;
      filtSel_q <= filtSel_d;
      romAddr_q <= romAddr_d;
      nfiltM1_q <= nfiltM1_d;
      nwordM1_q <= nwordM1_d;
      waitCnt_q <= waitCnt_d;
      kwData_q  <= kwData_d;
    end
  end

  // All control outputs are decoded from the registered state only, so they
  // are glitch-free and take their reset values the cycle after reset.
  assign F        = filtSel_q;
  assign rom_addr = romAddr_q;
  assign kw_data  = kwData_q;
  assign rom_en   = (state_q == FETCH);
  assign kw_valid = (state_q == HOLD);
  assign kw_last  = (state_q == HOLD) && lastWord;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_kw_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_kw_fetch_sequencer
//
// Two sequencer instances share the clock and reset: dutA uses a 1-cycle ROM
// and dutB a 3-cycle ROM. Each has a behavioural ROM + mux model whose output
// carries a pattern derived from filter and address, and a junk pattern when
// no read is pending. Stimulus tasks push the expected beat list into a
// per-instance queue; per-instance monitors pop and compare on every
// accepted beat. Directed checks cover timing, stalls, reset and run length.
// ---------------------------------------------------------------------------
module tb_kw_fetch_sequencer;

  localparam int KW_W   = 384;
  localparam int ADDR_W = 6;
  localparam logic [KW_W-1:0] ROM_IDLE = {12{32'hDEADBEEF}};

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic              startA, startB;
  logic [2:0]        nfiltA, nfiltB;
  logic [ADDR_W-1:0] nwordA, nwordB;
  logic [KW_W-1:0]   romKwA, romKwB;
  logic [2:0]        FA, FB;
  logic [ADDR_W-1:0] addrA, addrB;
  logic              romEnA, romEnB;
  logic [KW_W-1:0]   kwDataA, kwDataB;
  logic              kwValidA, kwValidB;
  logic              kwReadyA, kwReadyB;
  logic              kwLastA, kwLastB;
  logic              busyA, busyB;
  logic              doneA, doneB;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]        f;
    logic [ADDR_W-1:0] a;
    logic              last;
  } beat_t;

  beat_t expA[$];
  beat_t expB[$];

  kw_fetch_sequencer #(.KW_W(KW_W), .ADDR_W(ADDR_W), .ROM_LAT(1)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA),
    .cfg_nfilt_m1(nfiltA), .cfg_nword_m1(nwordA), .rom_kw_in(romKwA),
    .F(FA), .rom_addr(addrA), .rom_en(romEnA), .kw_data(kwDataA),
    .kw_valid(kwValidA), .kw_ready(kwReadyA), .kw_last(kwLastA),
    .busy(busyA), .done(doneA)
  );

  kw_fetch_sequencer #(.KW_W(KW_W), .ADDR_W(ADDR_W), .ROM_LAT(3)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB),
    .cfg_nfilt_m1(nfiltB), .cfg_nword_m1(nwordB), .rom_kw_in(romKwB),
    .F(FB), .rom_addr(addrB), .rom_en(romEnB), .kw_data(kwDataB),
    .kw_valid(kwValidB), .kw_ready(kwReadyB), .kw_last(kwLastB),
    .busy(busyB), .done(doneB)
  );

  // ROM content: every word encodes its filter and address in each lane.
  function automatic logic [KW_W-1:0] romWord(input logic [2:0] f, input logic [ADDR_W-1:0] a);
    romWord = {12{{16'hA5C3, 5'b0, f, 2'b0, a}}};
  endfunction

  // ROM models: data appears ROM_LAT edges after the enable; otherwise junk.
  logic [KW_W-1:0] romPipeA;
  logic [KW_W-1:0] romPipeB [3];

  always @(posedge clk) begin
    romPipeA    <= romEnA ? romWord(FA, addrA) : ROM_IDLE;
    romPipeB[0] <= romEnB ? romWord(FB, addrB) : ROM_IDLE;
    romPipeB[1] <= romPipeB[0];
    romPipeB[2] <= romPipeB[1];
  end

  assign romKwA = romPipeA;
  assign romKwB = romPipeB[2];

  task automatic checkOutput(input string name, input logic [KW_W-1:0] actual,
                             input logic [KW_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: compare every accepted beat against the queue head.
  always @(negedge clk) begin
    beat_t b;
    if (kwValidA === 1'b1 && kwReadyA === 1'b1) begin
      if (expA.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL A unexpected beat: got F=%0d addr=%0d, expected no beat", FA, addrA);
      end else begin
        b = expA.pop_front();
        checkOutput("A beat F", KW_W'(FA), KW_W'(b.f));
        checkOutput("A beat addr", KW_W'(addrA), KW_W'(b.a));
        checkOutput("A beat last", KW_W'(kwLastA), KW_W'(b.last));
        checkOutput("A beat data", kwDataA, romWord(b.f, b.a));
      end
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (kwValidB === 1'b1 && kwReadyB === 1'b1) begin
      if (expB.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL B unexpected beat: got F=%0d addr=%0d, expected no beat", FB, addrB);
      end else begin
        b = expB.pop_front();
        checkOutput("B beat F", KW_W'(FB), KW_W'(b.f));
        checkOutput("B beat addr", KW_W'(addrB), KW_W'(b.a));
        checkOutput("B beat last", KW_W'(kwLastB), KW_W'(b.last));
        checkOutput("B beat data", kwDataB, romWord(b.f, b.a));
      end
    end
  end

  // Starts a run (start high for the current cycle, called cycle 0) and
  // pushes the expected beat sequence for that configuration.
  task automatic applyStimulus(input bit sel, input int nf, input int nw);
    beat_t b;
    tick();
    if (sel) begin
      nfiltB = 3'(nf);
      nwordB = ADDR_W'(nw);
      startB = 1'b1;
    end else begin
      nfiltA = 3'(nf);
      nwordA = ADDR_W'(nw);
      startA = 1'b1;
    end
    for (int f = 0; f <= nf; f++) begin
      for (int a = 0; a <= nw; a++) begin
        b.f    = 3'(f);
        b.a    = ADDR_W'(a);
        b.last = (a == nw);
        if (sel) expB.push_back(b);
        else expA.push_back(b);
      end
    end
  endtask

  // Follows a run from cycle 0 until busy drops, recording beat timing and
  // done pulses. Optionally pokes start and cfg mid-run on instance A.
  task automatic watchRun(input bit sel, input int budget, input int expGap, input int pokeCycle,
                          output int beats, output int firstBeat, output int doneCyc,
                          output int doneCnt);
    int prevBeat;
    beats = 0;
    firstBeat = -1;
    doneCyc = -1;
    doneCnt = 0;
    prevBeat = -1;
    for (int c = 0; c <= budget; c++) begin
      @(negedge clk);
      if (sel ? (kwValidB && kwReadyB) : (kwValidA && kwReadyA)) begin
        if (prevBeat >= 0 && expGap > 0)
          checkOutput("beat spacing", KW_W'(c - prevBeat), KW_W'(expGap));
        if (prevBeat < 0) firstBeat = c;
        prevBeat = c;
        beats++;
      end
      if (sel ? doneB : doneA) begin
        doneCnt++;
        doneCyc = c;
      end
      if (c > 0 && !(sel ? busyB : busyA)) return;
      tick();
      if (c == 0) begin
        if (sel) startB = 1'b0;
        else startA = 1'b0;
      end
      if (c == pokeCycle) begin
        startA = 1'b1;
        nfiltA = 3'd7;
        nwordA = ADDR_W'(5);
      end
      if (c == pokeCycle + 1) startA = 1'b0;
    end
    checks++;
    errors++;
    $display("[TB] FAIL run timeout: got busy still high after %0d cycles, expected idle", budget);
  endtask

  logic [4:0] t1Exp [6];
  int beats, firstBeat, doneCyc, doneCnt;
  bit found;

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got no finish, expected finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    t1Exp = '{5'b00000, 5'b10001, 5'b00001, 5'b01101, 5'b00011, 5'b00000};
    rst_n    = 1'b0;
    startA   = 1'b0;
    startB   = 1'b0;
    nfiltA   = '0;
    nfiltB   = '0;
    nwordA   = '0;
    nwordB   = '0;
    kwReadyA = 1'b1;
    kwReadyB = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    @(negedge clk);
    checkOutput("reset A ctl", KW_W'({FA, addrA, romEnA, kwValidA, kwLastA, busyA, doneA}), '0);
    checkOutput("reset A data", kwDataA, '0);
    checkOutput("reset B ctl", KW_W'({FB, addrB, romEnB, kwValidB, kwLastB, busyB, doneB}), '0);

    $display("[TB] T1 single word, ROM_LAT=1");
    applyStimulus(1'b0, 0, 0);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("T1 en/valid/last/done/busy c%0d", c),
                  KW_W'({romEnA, kwValidA, kwLastA, doneA, busyA}), KW_W'(t1Exp[c]));
      tick();
      if (c == 0) startA = 1'b0;
    end
    checkOutput("T1 queue drained", KW_W'(expA.size()), '0);

    $display("[TB] T2 8 filters x 4 words");
    applyStimulus(1'b0, 7, 3);
    watchRun(1'b0, 300, 3, -1, beats, firstBeat, doneCyc, doneCnt);
    checkOutput("T2 beats", KW_W'(beats), KW_W'(32));
    checkOutput("T2 first beat", KW_W'(firstBeat), KW_W'(3));
    checkOutput("T2 done cycle", KW_W'(doneCyc), KW_W'(97));
    checkOutput("T2 done pulses", KW_W'(doneCnt), KW_W'(1));
    checkOutput("T2 queue drained", KW_W'(expA.size()), '0);

    $display("[TB] T3 backpressure on F2a1");
    applyStimulus(1'b0, 3, 3);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (c == 0) startA = 1'b0;
      if (kwValidA && FA == 3'd2 && addrA == ADDR_W'(1)) found = 1'b1;
    end
    checkOutput("T3 reached F2a1", KW_W'(found), KW_W'(1));
    if (found) begin
      kwReadyA = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        checkOutput("T3 stall valid/en/last", KW_W'({kwValidA, romEnA, kwLastA}), KW_W'(3'b100));
        checkOutput("T3 stall F/addr", KW_W'({FA, addrA}), KW_W'({3'd2, 6'd1}));
        checkOutput("T3 stall data", kwDataA, romWord(3'd2, 6'd1));
        tick();
      end
      kwReadyA = 1'b1;
      @(negedge clk);
      checkOutput("T3 valid at accept", KW_W'(kwValidA), KW_W'(1));
      tick();
      @(negedge clk);
      checkOutput("T3 fetch after ready", KW_W'({romEnA, kwValidA, FA, addrA}),
                  KW_W'({1'b1, 1'b0, 3'd2, 6'd2}));
      watchRun(1'b0, 200, 3, -1, beats, firstBeat, doneCyc, doneCnt);
      checkOutput("T3 done pulses", KW_W'(doneCnt), KW_W'(1));
    end
    checkOutput("T3 queue drained", KW_W'(expA.size()), '0);
    expA.delete();

    $display("[TB] T4 start and cfg poked mid-run");
    applyStimulus(1'b0, 1, 2);
    watchRun(1'b0, 200, 3, 6, beats, firstBeat, doneCyc, doneCnt);
    checkOutput("T4 beats", KW_W'(beats), KW_W'(6));
    checkOutput("T4 done cycle", KW_W'(doneCyc), KW_W'(19));
    checkOutput("T4 done pulses", KW_W'(doneCnt), KW_W'(1));
    checkOutput("T4 queue drained", KW_W'(expA.size()), '0);

    $display("[TB] T5 reset during WAIT of F3a2");
    applyStimulus(1'b0, 4, 3);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (c == 0) startA = 1'b0;
      if (romEnA && FA == 3'd3 && addrA == ADDR_W'(2)) found = 1'b1;
    end
    checkOutput("T5 reached F3a2 fetch", KW_W'(found), KW_W'(1));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("T5 reset ctl", KW_W'({FA, addrA, romEnA, kwValidA, kwLastA, busyA, doneA}), '0);
    checkOutput("T5 reset data", kwDataA, '0);
    expA.delete();
    applyStimulus(1'b0, 0, 1);
    watchRun(1'b0, 100, 3, -1, beats, firstBeat, doneCyc, doneCnt);
    checkOutput("T5 restart beats", KW_W'(beats), KW_W'(2));
    checkOutput("T5 restart first beat", KW_W'(firstBeat), KW_W'(3));
    checkOutput("T5 restart done cycle", KW_W'(doneCyc), KW_W'(7));
    checkOutput("T5 queue drained", KW_W'(expA.size()), '0);

    $display("[TB] T6 ROM_LAT=3");
    applyStimulus(1'b1, 1, 1);
    watchRun(1'b1, 200, 5, -1, beats, firstBeat, doneCyc, doneCnt);
    checkOutput("T6 beats", KW_W'(beats), KW_W'(4));
    checkOutput("T6 first beat", KW_W'(firstBeat), KW_W'(5));
    checkOutput("T6 done cycle", KW_W'(doneCyc), KW_W'(21));
    checkOutput("T6 done pulses", KW_W'(doneCnt), KW_W'(1));
    checkOutput("T6 queue drained", KW_W'(expB.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
